// File: rtl/mlaccel_qpi_pkg.sv
// Shared QPI target definitions: host command codes, FSM encoding, underrun fill byte.
package mlaccel_qpi_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h21;
  localparam logic [7:0] CMD_READ   = 8'h22;
  localparam logic [7:0] CMD_STATUS = 8'h23;

  localparam logic [7:0] UNDERRUN_BYTE_DEF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_TURN = 2'd2,
    ST_TX   = 2'd3
  } qpi_state_e;

endpackage

// File: rtl/qpi_sync.sv
// Oversamples csb/clk/io into `clock` (2 FFs, 3 with QPI_SYNC3_EN) and flags their edges.
// clk edges are suppressed while csb is high; csb resets low so a live transaction is never re-entered.
module qpi_sync
  import mlaccel_qpi_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       qpi_csb,
  input  logic       qpi_clk,
  input  logic [3:0] qpi_io_in,
  output logic       clk_rise,
  output logic       clk_fall,
  output logic       csb_fall,
  output logic       csb_rise,
  output logic [3:0] io_s
);

`ifdef QPI_SYNC3_EN
  localparam int STAGES = 3;
`else
  localparam int STAGES = 2;
`endif

  // Bit order per stage: {csb, clk, io[3:0]}.
  localparam logic [5:0] SYNC_RST = 6'b01_0000;

  logic [STAGES-1:0][5:0] sync_q;
  logic                   csb_d;
  logic                   clk_d;
  logic                   csb_s;
  logic                   clk_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{SYNC_RST}};
      csb_d  <= 1'b0;
      clk_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], {qpi_csb, qpi_clk, qpi_io_in}};
      csb_d  <= csb_s;
      clk_d  <= clk_s;
    end
  end

  assign csb_s    = sync_q[STAGES-1][5];
  assign clk_s    = sync_q[STAGES-1][4];
  assign io_s     = sync_q[STAGES-1][3:0];
  assign clk_rise = clk_s & ~clk_d & ~csb_s;
  assign clk_fall = ~clk_s & clk_d & ~csb_s;
  assign csb_fall = ~csb_s & csb_d;
  assign csb_rise = csb_s & ~csb_d;

endmodule

// File: rtl/qpi_target.sv
// Chip-side QPI responder: nibble->byte receive, turnaround, byte->nibble transmit with underrun fill.
// Pad outputs follow the pad edge by 3 clocks (4 with QPI_SYNC3_EN); tx pops via tx_ready, no rx backpressure.
module qpi_target
  import mlaccel_qpi_pkg::*;
#(
  parameter logic [7:0] UNDERRUN_BYTE = UNDERRUN_BYTE_DEF,
  parameter int          DUMMY_CYCLES  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       qpi_csb,
  input  logic       qpi_clk,
  input  logic [3:0] qpi_io_in,
  output logic [3:0] qpi_io_out,
  output logic       qpi_io_oe,
  output logic       qpi_rdy,
  output logic       qpi_err,
  input  logic       core_busy,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_first,
  output logic       rx_end,
  input  logic       turn_req,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready
);

  localparam int                DCW        = $clog2(DUMMY_CYCLES) + 1;
  localparam logic [DCW-1:0]    DUMMY_LAST = DCW'(DUMMY_CYCLES - 1);

  logic           clk_rise, clk_fall, csb_fall, csb_rise;
  logic [3:0]     io_s;
  qpi_state_e     state, state_nxt;
  logic           start, leave, byte_done, part_err, udr_err, tx_fall;
  logic [7:0]     tx_byte;
  logic           half;
  logic [3:0]     hi_nib;
  logic           first_pend;
  logic [DCW-1:0] dummy_cnt;
  logic [7:0]     cur_byte;

  qpi_sync u_sync (
    .clock     (clock),
    .reset     (reset),
    .qpi_csb   (qpi_csb),
    .qpi_clk   (qpi_clk),
    .qpi_io_in (qpi_io_in),
    .clk_rise  (clk_rise),
    .clk_fall  (clk_fall),
    .csb_fall  (csb_fall),
    .csb_rise  (csb_rise),
    .io_s      (io_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    leave     = 1'b0;
    byte_done = 1'b0;
    part_err  = 1'b0;
    tx_fall   = 1'b0;
    tx_byte   = UNDERRUN_BYTE;
    case (state)
      ST_IDLE: if (csb_fall) begin
        state_nxt = ST_RX;
        start     = 1'b1;
      end
      ST_RX: begin
        byte_done = clk_rise & half;
        if (turn_req) state_nxt = ST_TURN;
      end
      ST_TURN: if (clk_rise && dummy_cnt == DUMMY_LAST) state_nxt = ST_TX;
      ST_TX:   tx_fall = clk_fall;
      default: state_nxt = ST_IDLE;
    endcase
    // csb deassertion wins over everything; an odd nibble count means a torn byte.
    if (state != ST_IDLE && csb_rise) begin
      state_nxt = ST_IDLE;
      leave     = 1'b1;
      byte_done = 1'b0;
      tx_fall   = 1'b0;
      part_err  = (state == ST_RX) & half;
    end
    if (tx_valid) tx_byte = tx_data;
  end

  assign tx_ready = tx_fall & tx_valid;
  assign udr_err  = tx_fall & ~tx_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      qpi_io_out <= '0;
      qpi_io_oe  <= 1'b0;
      qpi_rdy    <= 1'b0;
      qpi_err    <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      rx_first   <= 1'b0;
      rx_end     <= 1'b0;
      half       <= 1'b0;
      hi_nib     <= '0;
      first_pend <= 1'b0;
      dummy_cnt  <= '0;
      cur_byte   <= '0;
    end else begin
      qpi_rdy  <= ~core_busy;
      rx_valid <= byte_done;
      rx_end   <= leave;
      qpi_err  <= (qpi_err & ~start) | part_err | udr_err;

      if (byte_done) begin
        rx_data    <= {hi_nib, io_s};
        rx_first   <= first_pend;
        first_pend <= 1'b0;
      end
      if (start) begin
        half       <= 1'b0;
        first_pend <= 1'b1;
      end else if (state == ST_RX && clk_rise) begin
        half   <= ~half;
        hi_nib <= io_s;
      end

      if (state != ST_TURN) dummy_cnt <= '0;
      else if (clk_rise)    dummy_cnt <= dummy_cnt + 1'b1;

      if (tx_fall) begin
        cur_byte   <= tx_byte;
        qpi_io_out <= tx_byte[7:4];
        qpi_io_oe  <= 1'b1;
      end else if (state == ST_TX && clk_rise) begin
        qpi_io_out <= cur_byte[3:0];
      end
      if (leave) begin
        qpi_io_oe  <= 1'b0;
        qpi_io_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_qpi_target.sv
// Bench for qpi_target: host QPI model drives framing, a tx source model feeds the core side, scoreboards check both directions.
module tb_qpi_target;
  import mlaccel_qpi_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       qpi_csb = 1'b1;
  logic       qpi_clk = 1'b1;
  logic [3:0] qpi_io_in = 4'h0;
  logic [3:0] qpi_io_out;
  logic       qpi_io_oe, qpi_rdy, qpi_err;
  logic       core_busy = 1'b0;
  logic       rx_valid, rx_first, rx_end;
  logic [7:0] rx_data;
  logic       turn_req = 1'b0;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_data;

  int         n_tests = 0;
  int         n_fail = 0;
  int         hp_ns = 50;
  int         rx_seen = 0;
  int         rx_end_seen = 0;
  logic [8:0] rx_exp_q[$];
  logic [7:0] rd_exp_q[$];
  logic [8:0] exp_rx;
  logic [7:0] tx_mem [64];
  int         tx_pops = 0;
  int         tx_len = 0;

  qpi_target dut (
    .clock      (clock),
    .reset      (reset),
    .qpi_csb    (qpi_csb),
    .qpi_clk    (qpi_clk),
    .qpi_io_in  (qpi_io_in),
    .qpi_io_out (qpi_io_out),
    .qpi_io_oe  (qpi_io_oe),
    .qpi_rdy    (qpi_rdy),
    .qpi_err    (qpi_err),
    .core_busy  (core_busy),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_first   (rx_first),
    .rx_end     (rx_end),
    .turn_req   (turn_req),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready)
  );

  always #5 clock = ~clock;

  // Core-side tx source: a byte store with a pop pointer advanced by tx_ready.
  assign tx_valid = (tx_pops < tx_len);
  assign tx_data  = tx_mem[tx_pops[5:0]];
  always @(posedge clock) if (tx_ready) tx_pops <= tx_pops + 1;

  always @(negedge clock) begin
    if (!reset && rx_valid) begin
      rx_seen++;
      n_tests++;
      if (rx_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rx_unexpected: got data %h first %b, required no byte", rx_data, rx_first);
      end else begin
        exp_rx = rx_exp_q.pop_front();
        if ({rx_first, rx_data} !== exp_rx) begin
          n_fail++;
          $display("FAIL rx_byte: got first %b data %h, required first %b data %h",
                   rx_first, rx_data, exp_rx[8], exp_rx[7:0]);
        end
      end
    end
    if (!reset && rx_end) rx_end_seen++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached after %0d comparisons, required completion", n_tests);
    $fatal(1, "watchdog expired");
  end

  task automatic host_start();
    @(negedge clock);
    qpi_csb = 1'b0;
    #(hp_ns);
  endtask

  task automatic host_nibble(input logic [3:0] n);
    qpi_clk   = 1'b0;
    qpi_io_in = n;
    #(hp_ns);
    qpi_clk   = 1'b1;
    #(hp_ns);
  endtask

  task automatic host_send(input logic [7:0] b, input logic first);
    rx_exp_q.push_back({first, b});
    host_nibble(b[7:4]);
    host_nibble(b[3:0]);
  endtask

  task automatic host_stop();
    #(hp_ns);
    qpi_csb = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic host_dummy();
    qpi_clk = 1'b0;
    #(hp_ns);
    qpi_clk = 1'b1;
    #(hp_ns);
  endtask

  task automatic host_read(output logic [7:0] b, output logic oe);
    qpi_clk = 1'b0;
    #(hp_ns);
    b[7:4] = qpi_io_out;
    oe     = qpi_io_oe;
    qpi_clk = 1'b1;
    #(hp_ns);
    b[3:0] = qpi_io_out;
    oe     = oe & qpi_io_oe;
  endtask

  task automatic queue_tx(input logic [7:0] b);
    tx_mem[tx_len[5:0]] = b;
    tx_len++;
    rd_exp_q.push_back(b);
  endtask

  task automatic pulse_turn();
    @(negedge clock);
    turn_req = 1'b1;
    @(negedge clock);
    turn_req = 1'b0;
  endtask

  task automatic wait_rx(input int target, input string what);
    int k = 0;
    while (rx_seen < target && k < 400) begin
      @(negedge clock);
      k++;
    end
    n_tests++;
    if (rx_seen < target) begin
      n_fail++;
      $display("FAIL %s_timeout: rx count %0d, required %0d", what, rx_seen, target);
    end
  endtask

  task automatic read_and_check(input string what, input int idx);
    logic [7:0] b;
    logic       oe;
    logic [7:0] e;
    host_read(b, oe);
    e = (rd_exp_q.size() != 0) ? rd_exp_q.pop_front() : 8'hxx;
    n_tests++;
    if (b !== e || oe !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_read%0d: got %h oe %b, required %h oe 1", what, idx, b, oe, e);
    end
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_tests++;
    if ({qpi_io_out, qpi_io_oe, qpi_rdy, qpi_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_pads: got out %h oe %b rdy %b err %b, required all 0",
               qpi_io_out, qpi_io_oe, qpi_rdy, qpi_err);
    end
    n_tests++;
    if ({rx_valid, rx_end, tx_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_strobes: got rx_valid %b rx_end %b tx_ready %b, required 000",
               rx_valid, rx_end, tx_ready);
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_tests++;
    if (qpi_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rdy_after_reset: got %b, required 1", qpi_rdy);
    end
  endtask

  task automatic test_rdy();
    logic [4:0] pat = 5'b10110;
    logic       prev = 1'b0;
    for (int i = 0; i < 5; i++) begin
      core_busy = pat[i];
      #1;
      n_tests++;
      if (qpi_rdy !== ~prev) begin
        n_fail++;
        $display("FAIL rdy_hold%0d: got %b, required %b", i, qpi_rdy, ~prev);
      end
      @(negedge clock);
      n_tests++;
      if (qpi_rdy !== ~pat[i]) begin
        n_fail++;
        $display("FAIL rdy_track%0d: got %b, required %b", i, qpi_rdy, ~pat[i]);
      end
      prev = pat[i];
    end
    core_busy = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_write_burst();
    int rx0 = rx_seen;
    int end0 = rx_end_seen;
    hp_ns = 17;
    host_start();
    host_send(CMD_WRITE, 1'b1);
    for (int i = 1; i <= 12; i++) host_send(8'(i), 1'b0);
    host_stop();
    hp_ns = 50;
    n_tests++;
    if (rx_seen - rx0 != 13) begin
      n_fail++;
      $display("FAIL burst_count: got %0d bytes, required 13", rx_seen - rx0);
    end
    n_tests++;
    if (rx_end_seen - end0 != 1) begin
      n_fail++;
      $display("FAIL burst_rx_end: got %0d pulses, required 1", rx_end_seen - end0);
    end
    n_tests++;
    if (qpi_err !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_err: got %b, required 0", qpi_err);
    end
  endtask

  task automatic test_status_poll();
    int rx0 = rx_seen;
    host_start();
    host_send(CMD_STATUS, 1'b1);
    host_send(8'h01, 1'b0);
    host_send(8'h10, 1'b0);
    wait_rx(rx0 + 3, "status_rx");
    queue_tx(8'h03);
    queue_tx(8'h02);
    queue_tx(8'h00);
    pulse_turn();
    qpi_clk = 1'b0;
    #(hp_ns);
    n_tests++;
    if (qpi_io_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL status_oe_dummy_low: got %b, required 0", qpi_io_oe);
    end
    qpi_clk = 1'b1;
    #(hp_ns);
    n_tests++;
    if (qpi_io_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL status_oe_dummy_rise: got %b, required 0", qpi_io_oe);
    end
    for (int i = 0; i < 3; i++) read_and_check("status", i);
    host_stop();
    n_tests++;
    if (qpi_err !== 1'b0) begin
      n_fail++;
      $display("FAIL status_err: got %b, required 0", qpi_err);
    end
  endtask

  task automatic test_underrun();
    int rx0 = rx_seen;
    host_start();
    host_send(CMD_READ, 1'b1);
    host_send(8'h03, 1'b0);
    host_send(8'h10, 1'b0);
    wait_rx(rx0 + 3, "underrun_rx");
    for (int i = 0; i < 5; i++) queue_tx(8'h40 + 8'(i));
    for (int i = 0; i < 15; i++) rd_exp_q.push_back(8'hFF);
    pulse_turn();
    host_dummy();
    for (int i = 0; i < 20; i++) begin
      read_and_check("underrun", i);
      if (i == 4 || i == 5) begin
        n_tests++;
        if (qpi_err !== (i == 5)) begin
          n_fail++;
          $display("FAIL underrun_err_after%0d: got %b, required %b", i + 1, qpi_err, (i == 5));
        end
      end
    end
    host_stop();
    n_tests++;
    if (qpi_err !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_err_sticky: got %b, required 1", qpi_err);
    end
  endtask

  task automatic test_partial();
    int rx0 = rx_seen;
    int end0 = rx_end_seen;
    host_start();
    n_tests++;
    if (qpi_err !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_err_cleared: got %b, required 0", qpi_err);
    end
    host_send(8'h5A, 1'b1);
    host_nibble(4'h3);
    host_stop();
    n_tests++;
    if (rx_seen - rx0 != 1 || rx_end_seen - end0 != 1) begin
      n_fail++;
      $display("FAIL partial_counts: got %0d bytes %0d ends, required 1 and 1",
               rx_seen - rx0, rx_end_seen - end0);
    end
    n_tests++;
    if (qpi_err !== 1'b1 || qpi_io_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_flags: got err %b oe %b, required err 1 oe 0", qpi_err, qpi_io_oe);
    end
  endtask

  task automatic test_reset_mid_tx();
    int rx0 = rx_seen;
    int rx1;
    host_start();
    host_send(CMD_READ, 1'b1);
    host_send(8'h01, 1'b0);
    wait_rx(rx0 + 2, "midtx_rx");
    queue_tx(8'hA1);
    queue_tx(8'hA2);
    queue_tx(8'hA3);
    pulse_turn();
    host_dummy();
    read_and_check("midtx", 0);
    qpi_clk = 1'b0;
    #(hp_ns);
    n_tests++;
    if (qpi_io_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL midtx_oe_before_reset: got %b, required 1", qpi_io_oe);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (qpi_io_oe !== 1'b0 || qpi_io_out !== 4'h0) begin
      n_fail++;
      $display("FAIL midtx_reset_pads: got oe %b out %h, required oe 0 out 0", qpi_io_oe, qpi_io_out);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    tx_len = tx_pops;
    rd_exp_q.delete();
    rx1 = rx_seen;
    qpi_clk = 1'b1;
    #(hp_ns);
    qpi_csb = 1'b1;
    repeat (10) @(negedge clock);
    host_start();
    host_send(CMD_WRITE, 1'b1);
    host_send(8'hA5, 1'b0);
    host_stop();
    n_tests++;
    if (rx_seen - rx1 != 2 || rx_exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midtx_next_txn: got %0d bytes %0d pending, required 2 and 0",
               rx_seen - rx1, rx_exp_q.size());
    end
    n_tests++;
    if (qpi_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midtx_next_err: got %b, required 0", qpi_err);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) tx_mem[i] = 8'h00;
    test_reset();
    test_rdy();
    test_write_burst();
    test_status_poll();
    test_underrun();
    test_partial();
    test_reset_mid_tx();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
